// File: rtl/systolic_drain_if.sv
// South-edge drain bundle: skewed partial sums in, aligned rows out over valid/ready,
// plus almost-full throttle and sticky overflow back to the array controller.
interface systolic_drain_if #(
    parameter int COLS  = 4,
    parameter int ACC_W = 32
);
    logic                    i_valid;
    logic [COLS*ACC_W-1:0]   i_south;
    logic                    i_ready;
    logic [COLS*ACC_W-1:0]   o_data;
    logic                    o_valid;
    logic                    o_almost_full;
    logic                    o_overflow;

    modport slave (
        input  i_valid, i_south, i_ready,
        output o_data, o_valid, o_almost_full, o_overflow
    );

    modport master (
        output i_valid, i_south, i_ready,
        input  o_data, o_valid, o_almost_full, o_overflow
    );
endinterface

// File: rtl/systolic_drain.sv
// Deskews south partial sums into rows and queues them; a row appears COLS cycles after its column-0 valid.
// Backpressure holds the FIFO head; o_almost_full throttles launches, a push into a full FIFO without a pop is dropped.
module systolic_drain #(
    parameter int COLS  = 4,
    parameter int ACC_W = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    systolic_drain_if.slave bus
);
    localparam int ROW_W = COLS * ACC_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + COLS) + 1;
    localparam int SR_N  = (COLS > 1) ? COLS - 1 : 1;

    logic [SR_N-1:0]  vld_sr_q;
    logic             aligned_vld;
    logic [ROW_W-1:0] row_aligned;

    generate
        if (COLS > 1) begin : g_vsr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_sr_q <= '0;
                end else begin
                    vld_sr_q[0] <= bus.i_valid;
                    for (int k = 1; k < SR_N; k++) begin
                        vld_sr_q[k] <= vld_sr_q[k-1];
                    end
                end
            end
            assign aligned_vld = vld_sr_q[SR_N-1];
        end else begin : g_nvsr
            assign vld_sr_q    = '0;
            assign aligned_vld = bus.i_valid;
        end
    endgenerate

    // Column c arrives c cycles late, so it waits COLS-1-c stages to line up with the last column.
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int D = COLS - 1 - c;
            if (D == 0) begin : g_direct
                assign row_aligned[c*ACC_W +: ACC_W] = bus.i_south[c*ACC_W +: ACC_W];
            end else begin : g_dly
                logic [ACC_W-1:0] dsk_q [D];
                always_ff @(posedge clk) begin
                    dsk_q[0] <= bus.i_south[c*ACC_W +: ACC_W];
                    for (int k = 1; k < D; k++) begin
                        dsk_q[k] <= dsk_q[k-1];
                    end
                end
                assign row_aligned[c*ACC_W +: ACC_W] = dsk_q[D-1];
            end
        end
    endgenerate

    logic [ROW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    inflight;
    logic             ov_q, ov_d;
    logic             out_vld;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign out_vld = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = out_vld && bus.i_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign wr_en   = aligned_vld && (!full || pop);
    assign drop    = aligned_vld && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ov_d     = ov_q | drop;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(pop);
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < SR_N; k++) begin
            inflight = inflight + CW'(vld_sr_q[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_q     <= ov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= row_aligned;
        end
    end

    assign bus.o_valid       = out_vld;
    assign bus.o_data        = out_vld ? mem_q[rd_ptr_q] : '0;
    assign bus.o_almost_full = ((count_q + inflight) >= CW'(DEPTH));
    assign bus.o_overflow    = ov_q;
endmodule
